wdt_timebase: RTL and testbench

- Free-running watchdog timebase in the clk_wdt domain. Produces the one-cycle overflow strobe that the shared TMR0/WDT prescaler consumes, either as the WDT postscaler input or directly as the WDT timeout.
- Receives CLRWDT/SLEEP clear requests from the core (clk) domain over a toggle handshake and returns an acknowledge toggle.
- Sits directly upstream of the TMR0/WDT prescaler block and replaces its local WDT counter.

---
 rtl/wdt_timebase.sv | 95 +++++++++
 tb/tb_wdt_timebase.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wdt_timebase.sv
// Watchdog timebase in the clk_wdt domain: free-running counter with one-cycle overflow strobe
// and a toggle-handshake clear. Optional sticky timeout flag under WDT_TIMEOUT_LATCH_EN.
module wdt_timebase #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2   // minimum 2
) (
    input  logic             clk_wdt,
    input  logic             rst,
    input  logic             wdt_en,
    input  logic             clr_req_tgl,
    output logic             clr_ack_tgl,
    output logic             wdt_ovf,
    output logic [CNT_W-1:0] wdt_cnt,
    output logic             wdt_to_flag
);

    typedef enum logic {S_OFF, S_RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   en_s;
    logic                   req_s;
    logic                   req_d;
    logic                   clr_pulse;
    logic                   ovf_set;

    always_ff @(posedge clk_wdt) begin
        if (rst) begin
            en_sync  <= '0;
            req_sync <= '0;
        end else begin
            en_sync  <= {en_sync[SYNC_STAGES-2:0], wdt_en};
            req_sync <= {req_sync[SYNC_STAGES-2:0], clr_req_tgl};
        end
    end

    assign en_s      = en_sync[SYNC_STAGES-1];
    assign req_s     = req_sync[SYNC_STAGES-1];
    assign clr_pulse = req_s ^ req_d;

    // A clear or a falling enable in the same cycle suppresses the wrap strobe.
    assign ovf_set = (state == S_RUN) && en_s && !clr_pulse && (wdt_cnt == CNT_MAX);

    always_ff @(posedge clk_wdt) begin
        if (rst) begin
            state       <= S_OFF;
            wdt_cnt     <= '0;
            wdt_ovf     <= 1'b0;
            clr_ack_tgl <= 1'b0;
            req_d       <= 1'b0;
        end else begin
            req_d   <= req_s;
            wdt_ovf <= ovf_set;
            if (clr_pulse) begin
                clr_ack_tgl <= req_s;
            end
            case (state)
                S_OFF: begin
                    wdt_cnt <= '0;
                    if (en_s) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!en_s) begin
                        state   <= S_OFF;
                        wdt_cnt <= '0;
                    end else if (clr_pulse) begin
                        wdt_cnt <= '0;
                    end else begin
                        wdt_cnt <= wdt_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef WDT_TIMEOUT_LATCH_EN
    always_ff @(posedge clk_wdt) begin
        if (rst) begin
            wdt_to_flag <= 1'b0;
        end else if (clr_pulse) begin
            wdt_to_flag <= 1'b0;
        end else if (ovf_set) begin
            wdt_to_flag <= 1'b1;
        end
    end
`else
    assign wdt_to_flag = 1'b0;
`endif

endmodule

// File: tb/tb_wdt_timebase.sv
// Bench for wdt_timebase: expected overflow/ack events are queued when stimulus is applied and
// matched by a monitor as the DUT produces them; counter and flag are spot-checked.
module tb_wdt_timebase;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int PERIOD      = 1 << CNT_W;
`ifdef WDT_TIMEOUT_LATCH_EN
    localparam int LATCH = 1;
`else
    localparam int LATCH = 0;
`endif

    typedef struct {
        int cyc;
        int val;
    } ack_exp_t;

    logic             clk_wdt = 1'b0;
    logic             rst;
    logic             wdt_en;
    logic             clr_req_tgl;
    logic             clr_ack_tgl;
    logic             wdt_ovf;
    logic [CNT_W-1:0] wdt_cnt;
    logic             wdt_to_flag;

    int       cyc = 0;
    int       chk_cnt = 0;
    int       pass_cnt = 0;
    bit       mon_en = 1'b0;
    logic     ack_prev = 1'b0;
    int       ovf_q[$];
    ack_exp_t ack_q[$];

    wdt_timebase #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_wdt    (clk_wdt),
        .rst        (rst),
        .wdt_en     (wdt_en),
        .clr_req_tgl(clr_req_tgl),
        .clr_ack_tgl(clr_ack_tgl),
        .wdt_ovf    (wdt_ovf),
        .wdt_cnt    (wdt_cnt),
        .wdt_to_flag(wdt_to_flag)
    );

    always #5 clk_wdt = ~clk_wdt;

    always @(posedge clk_wdt) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk_wdt);
    endtask

    // Monitor: every strobe and every ack edge must match the head of its queue.
    always @(negedge clk_wdt) begin
        if (mon_en) begin
            if (wdt_ovf) begin
                if (ovf_q.size() == 0) check_val("ovf_unexpected", cyc, -1);
                else check_val("ovf_cycle", cyc, ovf_q.pop_front());
            end
            if (clr_ack_tgl != ack_prev) begin
                if (ack_q.size() == 0) begin
                    check_val("ack_unexpected", cyc, -1);
                end else begin
                    ack_exp_t e;
                    e = ack_q.pop_front();
                    check_val("ack_cycle", cyc, e.cyc);
                    check_val("ack_value", int'(clr_ack_tgl), e.val);
                end
            end
        end
        ack_prev <= clr_ack_tgl;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int r, b, b1, c, d, e, f, g;
        rst = 1'b1;
        wdt_en = 1'b1;
        clr_req_tgl = 1'b0;
        repeat (3) @(negedge clk_wdt);
        check_val("rst_cnt", int'(wdt_cnt), 0);
        check_val("rst_ovf", int'(wdt_ovf), 0);
        check_val("rst_ack", int'(clr_ack_tgl), 0);
        check_val("rst_flag", int'(wdt_to_flag), 0);

        // Test 1: start-up latency and free-running period.
        r = cyc;
        rst = 1'b0;
        mon_en = 1'b1;
        b = r + SYNC_STAGES + 1;
        ovf_q.push_back(b + PERIOD);
        ovf_q.push_back(b + 2 * PERIOD);
        wait_cyc(r + 2); check_val("start_cnt_off", int'(wdt_cnt), 0);
        wait_cyc(b);     check_val("start_cnt_run", int'(wdt_cnt), 0);
        wait_cyc(b + 1); check_val("start_cnt_1", int'(wdt_cnt), 1);
        wait_cyc(b + 100); check_val("cnt_100", int'(wdt_cnt), 100);
        wait_cyc(b + 255); check_val("flag_before_ovf", int'(wdt_to_flag), 0);
        check_val("cnt_255", int'(wdt_cnt), 255);
        wait_cyc(b + 300); check_val("flag_after_ovf", int'(wdt_to_flag), LATCH);

        // Test 2: clear at cnt=100.
        b1 = b + 2 * PERIOD;
        wait_cyc(b1 + 100);
        check_val("pre_clr_cnt", int'(wdt_cnt), 100);
        clr_req_tgl = 1'b1;
        c = b1 + 103;
        ack_q.push_back('{c, 1});
        ovf_q.push_back(c + PERIOD);
        wait_cyc(c - 1); check_val("clr_cnt_before", int'(wdt_cnt), 102);
        check_val("clr_flag_before", int'(wdt_to_flag), LATCH);
        wait_cyc(c); check_val("clr_cnt", int'(wdt_cnt), 0);
        check_val("clr_ack", int'(clr_ack_tgl), 1);
        check_val("clr_flag", int'(wdt_to_flag), 0);

        // Test 3: clear landing on the wrap edge suppresses the strobe.
        d = c + PERIOD;
        wait_cyc(d + PERIOD - 3);
        clr_req_tgl = 1'b0;
        ack_q.push_back('{d + PERIOD, 0});
        ovf_q.push_back(d + 2 * PERIOD);
        ovf_q.push_back(d + 3 * PERIOD);
        wait_cyc(d + PERIOD - 1); check_val("wrap_cnt_255", int'(wdt_cnt), 255);
        check_val("wrap_flag_set", int'(wdt_to_flag), LATCH);
        wait_cyc(d + PERIOD); check_val("wrap_clr_ovf", int'(wdt_ovf), 0);
        check_val("wrap_clr_cnt", int'(wdt_cnt), 0);
        check_val("wrap_clr_ack", int'(clr_ack_tgl), 0);
        check_val("wrap_clr_flag", int'(wdt_to_flag), 0);
        wait_cyc(d + PERIOD + 1); check_val("wrap_cnt_1", int'(wdt_cnt), 1);
        wait_cyc(d + 3 * PERIOD - 50); check_val("flag_held", int'(wdt_to_flag), LATCH);

        // Test 4: disable mid-count, then re-enable.
        e = d + 3 * PERIOD;
        wait_cyc(e + 50);
        check_val("dis_cnt_50", int'(wdt_cnt), 50);
        wdt_en = 1'b0;
        wait_cyc(e + 52); check_val("dis_cnt_52", int'(wdt_cnt), 52);
        wait_cyc(e + 53); check_val("dis_cnt_0", int'(wdt_cnt), 0);
        wait_cyc(e + 60); check_val("dis_flag_kept", int'(wdt_to_flag), LATCH);
        wait_cyc(e + 400); check_val("dis_cnt_held", int'(wdt_cnt), 0);
        f = cyc;
        wdt_en = 1'b1;
        ovf_q.push_back(f + 3 + PERIOD);
        wait_cyc(f + 3); check_val("ren_cnt_0", int'(wdt_cnt), 0);
        wait_cyc(f + 13); check_val("ren_cnt_10", int'(wdt_cnt), 10);

        // Test 5: request held high through reset gives exactly one clear.
        wait_cyc(f + 3 + PERIOD + 11);
        g = cyc;
        rst = 1'b1;
        clr_req_tgl = 1'b1;
        wait_cyc(g + 3);
        check_val("rst2_cnt", int'(wdt_cnt), 0);
        check_val("rst2_flag", int'(wdt_to_flag), 0);
        check_val("rst2_ack", int'(clr_ack_tgl), 0);
        rst = 1'b0;
        ack_q.push_back('{g + 6, 1});
        ovf_q.push_back(g + 6 + PERIOD);
        wait_cyc(g + 100);
        check_val("rst2_ack_settled", int'(clr_ack_tgl), 1);
        check_val("rst2_cnt_94", int'(wdt_cnt), 94);
        wait_cyc(g + 6 + PERIOD + 5);
        check_val("rst2_flag_ovf", int'(wdt_to_flag), LATCH);

        check_val("ovf_q_left", ovf_q.size(), 0);
        check_val("ack_q_left", ack_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
